imsic_msi_arb: RTL and testbench

- Round-robin scheduler that shares the single MSI delivery channel (msi_info / msi_info_vld) of one IMSIC hart gate between NR_REQ MSI sources, e.g. bus slave ports and the IPI generator.
- Accepts one MSI per grant, then drives the info/valid pair with the pulse shape the gate's synchronizer and rising-edge detector require.
- Keeps info stable until the gate has captured it.

---
 rtl/imsic_msi_arb_pkg.sv | 14 +
 rtl/imsic_msi_arb_rr_arb.sv | 45 ++++
 rtl/imsic_msi_arb.sv | 132 +++++++++++++
 tb/tb_imsic_msi_arb.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/imsic_msi_arb_pkg.sv
// Shared types and constants for the IMSIC MSI round-robin scheduler.
// State encoding, default info width and statistics counter width.
package imsic_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        DRIVE = 2'b01,
        GAP   = 2'b10
    } arb_state_e;

    localparam int MSI_INFO_WIDTH_DEF = 17;
    localparam int STAT_W             = 16;

endpackage

// File: rtl/imsic_msi_arb_rr_arb.sv
// Rotate-priority pick: first valid requester at or above ptr, with wrap.
// Owns the round-robin pointer, advanced past the winner on each accept.
module imsic_rr_arb #(
    parameter int NR_REQ = 4,
    parameter int IDX_W  = $clog2(NR_REQ)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NR_REQ-1:0] i_req_vld,
    input  logic              i_adv,
    output logic [NR_REQ-1:0] o_oh,
    output logic [IDX_W-1:0]  o_idx,
    output logic              o_any
);
    import imsic_pkg::*;

    logic [IDX_W-1:0] r_ptr;
    int               w_j;

    // Scan upward from ptr and take the first valid requester
    always_comb begin
        o_oh  = '0;
        o_idx = '0;
        o_any = 1'b0;
        w_j   = 0;
        for (int k = 0; k < NR_REQ; k++) begin
            w_j = (int'(r_ptr) + k) % NR_REQ;
            if (!o_any && i_req_vld[w_j]) begin
                o_any     = 1'b1;
                o_oh[w_j] = 1'b1;
                o_idx     = IDX_W'(w_j);
            end
        end
    end

    // Pointer moves to the slot after the winner only when a transfer occurs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (i_adv) begin
            r_ptr <= (o_idx == IDX_W'(NR_REQ - 1)) ? '0 : o_idx + IDX_W'(1);
        end
    end

endmodule

// File: rtl/imsic_msi_arb.sv
// Round-robin MSI scheduler feeding one IMSIC hart gate (info/vld pulse).
// Optional per-requester grant counters under IMSIC_MSI_ARB_STAT_EN.
module imsic_msi_arb
    import imsic_pkg::*;
#(
    parameter int NR_REQ         = 4,
    parameter int MSI_INFO_WIDTH = MSI_INFO_WIDTH_DEF,
    parameter int HOLD_CYC       = 4,
    parameter int GAP_CYC        = 4,
    parameter int CNT_W          =
        $clog2(((HOLD_CYC > GAP_CYC) ? HOLD_CYC : GAP_CYC) + 1),
    parameter int IDX_W          = $clog2(NR_REQ)
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NR_REQ-1:0]                req_vld,
    input  logic [NR_REQ*MSI_INFO_WIDTH-1:0] req_info,
    output logic [NR_REQ-1:0]                req_rdy,
    output logic [MSI_INFO_WIDTH-1:0]        o_msi_info,
    output logic                             o_msi_info_vld,
    output logic                             busy,
`ifdef IMSIC_MSI_ARB_STAT_EN
    input  logic                             stat_clr,
    output logic [NR_REQ*STAT_W-1:0]         o_grant_cnt,
`endif
    output logic [IDX_W-1:0]                 grant_id
);

    arb_state_e          r_state;
    arb_state_e          w_state_nx;
    logic [CNT_W-1:0]    r_cnt;
    logic [CNT_W-1:0]    w_cnt_nx;
    logic                w_accept;
    logic [NR_REQ-1:0]   w_oh;
    logic [IDX_W-1:0]    w_idx;
    logic                w_any;

    imsic_rr_arb #(
        .NR_REQ (NR_REQ),
        .IDX_W  (IDX_W)
    ) u_rr (
        .clk       (clk),
        .rst       (rst),
        .i_req_vld (req_vld),
        .i_adv     (w_accept),
        .o_oh      (w_oh),
        .o_idx     (w_idx),
        .o_any     (w_any)
    );

    // Next-state, phase counter and accept decode
    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        w_accept   = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_any && !rst) begin
                    w_accept   = 1'b1;
                    w_state_nx = DRIVE;
                    w_cnt_nx   = CNT_W'(HOLD_CYC - 1);
                end
            end
            DRIVE: begin
                if (r_cnt == '0) begin
                    w_state_nx = GAP;
                    w_cnt_nx   = CNT_W'(GAP_CYC - 1);
                end else begin
                    w_cnt_nx = r_cnt - CNT_W'(1);
                end
            end
            GAP: begin
                if (r_cnt == '0) begin
                    w_state_nx = IDLE;
                end else begin
                    w_cnt_nx = r_cnt - CNT_W'(1);
                end
            end
            default: begin
                w_state_nx = IDLE;
                w_cnt_nx   = '0;
            end
        endcase
    end

    // State and phase counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
        end
    end

    // Capture the winner's info and index on accept; hold otherwise
    always_ff @(posedge clk) begin
        if (rst) begin
            o_msi_info <= '0;
            grant_id   <= '0;
        end else if (w_accept) begin
            o_msi_info <= req_info[int'(w_idx)*MSI_INFO_WIDTH +: MSI_INFO_WIDTH];
            grant_id   <= w_idx;
        end
    end

    assign req_rdy        = (r_state == IDLE && !rst) ? w_oh : '0;
    assign o_msi_info_vld = (r_state == DRIVE);
    assign busy           = (r_state != IDLE);

`ifdef IMSIC_MSI_ARB_STAT_EN
    logic [NR_REQ*STAT_W-1:0] r_gcnt;

    // Saturating per-requester grant counters; clear beats increment
    always_ff @(posedge clk) begin
        if (rst || stat_clr) begin
            r_gcnt <= '0;
        end else if (w_accept) begin
            for (int i = 0; i < NR_REQ; i++) begin
                if (w_oh[i] && r_gcnt[i*STAT_W +: STAT_W] != '1) begin
                    r_gcnt[i*STAT_W +: STAT_W] <=
                        r_gcnt[i*STAT_W +: STAT_W] + STAT_W'(1);
                end
            end
        end
    end

    assign o_grant_cnt = r_gcnt;
`endif

endmodule

// File: tb/tb_imsic_msi_arb.sv
// Self-checking bench for imsic_msi_arb (NR_REQ=4, HOLD=4, GAP=4).
// Covers stat counters when IMSIC_MSI_ARB_STAT_EN is defined.
module tb_imsic_msi_arb;
    import imsic_pkg::*;

    localparam int N = 4;
    localparam int W = 17;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req_vld;
    logic [N*W-1:0] req_info;
    logic [N-1:0]   req_rdy;
    logic [W-1:0]   o_msi_info;
    logic           o_msi_info_vld;
    logic           busy;
    logic [1:0]     grant_id;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

`ifdef IMSIC_MSI_ARB_STAT_EN
    logic           stat_clr;
    logic [N*16-1:0] o_grant_cnt;
    imsic_msi_arb #(.NR_REQ(N), .MSI_INFO_WIDTH(W),
                    .HOLD_CYC(4), .GAP_CYC(4)) dut (
        .clk(clk), .rst(rst), .req_vld(req_vld), .req_info(req_info),
        .req_rdy(req_rdy), .o_msi_info(o_msi_info),
        .o_msi_info_vld(o_msi_info_vld), .busy(busy),
        .stat_clr(stat_clr), .o_grant_cnt(o_grant_cnt),
        .grant_id(grant_id));
`else
    imsic_msi_arb #(.NR_REQ(N), .MSI_INFO_WIDTH(W),
                    .HOLD_CYC(4), .GAP_CYC(4)) dut (
        .clk(clk), .rst(rst), .req_vld(req_vld), .req_info(req_info),
        .req_rdy(req_rdy), .o_msi_info(o_msi_info),
        .o_msi_info_vld(o_msi_info_vld), .busy(busy),
        .grant_id(grant_id));
`endif

    typedef struct {
        logic         vld;
        logic         bsy;
        logic [W-1:0] info;
    } vec_t;

    vec_t vt[1:9];
    int   exp_cyc[5];
    int   exp_req[5];

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        req_vld = '0;
`ifdef IMSIC_MSI_ARB_STAT_EN
        stat_clr = 1'b0;
`endif
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 30) begin
            step();
            n++;
        end
        chk("idle_timeout", 64'(busy), 64'd0);
    endtask

    initial begin
        int k;
        int pulses;
        rst      = 1'b1;
        req_vld  = 4'hF;
        req_info = '0;
`ifdef IMSIC_MSI_ARB_STAT_EN
        stat_clr = 1'b0;
`endif
        for (int c = 1; c <= 9; c++) begin
            vt[c].vld  = (c <= 4);
            vt[c].bsy  = (c <= 8);
            vt[c].info = 17'h01005;
        end
        exp_cyc = '{0, 9, 18, 27, 36};
        exp_req = '{0, 1, 2, 3, 0};

        // reset state, req_vld high but no rdy during rst
        step();
        step();
        #1;
        chk("rst_rdy", 64'(req_rdy), 64'd0);
        chk("rst_vld", 64'(o_msi_info_vld), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_gid", 64'(grant_id), 64'd0);
        chk("rst_info", 64'(o_msi_info), 64'd0);

        // single req2 pulse shape
        do_reset();
        req_info[2*W +: W] = 17'h01005;
        req_vld = 4'b0100;
        #1;
        chk("t1_rdy", 64'(req_rdy), 64'b0100);
        step();
        req_vld = '0;
        for (int c = 1; c <= 9; c++) begin
            #1;
            chk($sformatf("t1_vld_c%0d", c), 64'(o_msi_info_vld),
                64'(vt[c].vld));
            chk($sformatf("t1_busy_c%0d", c), 64'(busy), 64'(vt[c].bsy));
            chk($sformatf("t1_info_c%0d", c), 64'(o_msi_info),
                64'(vt[c].info));
            if (c < 9) step();
        end
        chk("t1_gid", 64'(grant_id), 64'd2);

        // fairness with all requesters valid
        do_reset();
        for (int i = 0; i < N; i++) req_info[i*W +: W] = W'(17'h100 + i);
        req_vld = 4'hF;
        k = 0;
        for (int cyc = 0; cyc < 45; cyc++) begin
            #1;
            if (req_rdy != '0) begin
                if (k < 5) begin
                    chk($sformatf("rr_cyc%0d", k), 64'(cyc), 64'(exp_cyc[k]));
                    chk($sformatf("rr_oh%0d", k), 64'(req_rdy),
                        64'(1 << exp_req[k]));
                end
                k++;
            end
            step();
        end
        chk("rr_count", 64'(k), 64'd5);
        req_vld = '0;
        wait_idle();

        // ptr=2 after granting req1; req3 beats req1
        do_reset();
        req_vld = 4'b0010;
        #1;
        chk("t3_rdy1", 64'(req_rdy), 64'b0010);
        step();
        req_vld = '0;
        wait_idle();
        req_vld = 4'b1010;
        #1;
        chk("t3_rdy3", 64'(req_rdy), 64'b1000);
        step();
        req_vld = 4'b0010;
        #1;
        chk("t3_gid3", 64'(grant_id), 64'd3);
        wait_idle();
        #1;
        chk("t3_rdy1b", 64'(req_rdy), 64'b0010);
        step();
        req_vld = '0;
        #1;
        chk("t3_gid1", 64'(grant_id), 64'd1);
        wait_idle();

        // reset in the second DRIVE cycle
        do_reset();
        req_info[0 +: W] = 17'h1ABCD;
        req_vld = 4'b0001;
        #1;
        chk("t4_rdy", 64'(req_rdy), 64'b0001);
        step();
        req_vld = '0;
        step();
        chk("t4_vld_pre", 64'(o_msi_info_vld), 64'd1);
        rst = 1'b1;
        req_vld = 4'b1001;
        #1;
        chk("t4_rdy_rst", 64'(req_rdy), 64'd0);
        step();
        chk("t4_vld", 64'(o_msi_info_vld), 64'd0);
        chk("t4_busy", 64'(busy), 64'd0);
        chk("t4_info", 64'(o_msi_info), 64'd0);
        rst = 1'b0;
        #1;
        chk("t4_rdy_post", 64'(req_rdy), 64'b0001);
        step();
        req_vld = '0;
        chk("t4_vld_post", 64'(o_msi_info_vld), 64'd1);
        chk("t4_info_post", 64'(o_msi_info), 64'h1ABCD);
        chk("t4_gid_post", 64'(grant_id), 64'd0);
        wait_idle();

        // req0 pulses valid while busy: no accept, no extra pulse
        do_reset();
        req_vld = 4'b0100;
        step();
        req_vld = '0;
        step();
        step();
        req_vld = 4'b0001;
        #1;
        chk("t5_rdy_busy", 64'(req_rdy), 64'd0);
        step();
        req_vld = '0;
        wait_idle();
        pulses = 0;
        for (int c = 0; c < 12; c++) begin
            #1;
            if (o_msi_info_vld) pulses++;
            step();
        end
        chk("t5_pulses", 64'(pulses), 64'd0);
        chk("t5_gid", 64'(grant_id), 64'd2);
        chk("t5_busy", 64'(busy), 64'd0);

`ifdef IMSIC_MSI_ARB_STAT_EN
        do_reset();
        for (int g = 0; g < 3; g++) begin
            req_vld = 4'b0010;
            step();
            req_vld = '0;
            wait_idle();
        end
        chk("st_cnt1", 64'(o_grant_cnt[16 +: 16]), 64'd3);
        force dut.r_gcnt[15:0] = 16'hFFFF;
        step();
        release dut.r_gcnt[15:0];
        req_vld = 4'b0001;
        step();
        req_vld = '0;
        step();
        chk("st_sat0", 64'(o_grant_cnt[0 +: 16]), 64'hFFFF);
        wait_idle();
        req_vld = 4'b0010;
        stat_clr = 1'b1;
        step();
        req_vld = '0;
        stat_clr = 1'b0;
        #1;
        chk("st_clr1", 64'(o_grant_cnt[16 +: 16]), 64'd0);
        chk("st_clr0", 64'(o_grant_cnt[0 +: 16]), 64'd0);
        wait_idle();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
